// File: rtl/seq_shift_rotate_pkg.sv
// Shared definitions for the sequential shift/rotate unit: op codes, FSM
// state encodings and default datapath sizes.
package seq_shift_rotate_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AMT_W_DEF = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ROR = 2'b10,
    SH_ASR = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shift_rotate_step.sv
// One-bit-position shift/rotate step: given the current operand and op,
// produce the operand after one step and the bit that fell out.
module seq_shift_rotate_step
  import seq_shift_rotate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val,
  output logic             o_carry
);

  always_comb begin
    o_val   = i_val;
    o_carry = 1'b0;
    case (i_op)
      SH_LSL: begin
        o_carry = i_val[WIDTH-1];
        o_val   = {i_val[WIDTH-2:0], 1'b0};
      end
      SH_LSR: begin
        o_carry = i_val[0];
        o_val   = {1'b0, i_val[WIDTH-1:1]};
      end
      SH_ROR: begin
        o_carry = i_val[0];
        o_val   = {i_val[0], i_val[WIDTH-1:1]};
      end
      SH_ASR: begin
        o_carry = i_val[0];
        o_val   = {i_val[WIDTH-1], i_val[WIDTH-1:1]};
      end
      default: begin
        o_carry = 1'b0;
        o_val   = i_val;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_rotate.sv
// Multi-cycle shift/rotate unit: captures an operand on start, then moves it
// one bit position per clock until the captured amount is exhausted.
module seq_shift_rotate
  import seq_shift_rotate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] source_1,
  input  logic [AMT_W-1:0] number_bits,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out
);

  localparam logic [AMT_W-1:0] AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};
  localparam logic [AMT_W-1:0] AMT_ZERO = '0;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_accept;
  logic [1:0]       r_op;
  logic [AMT_W-1:0] r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_step_out;
  logic             w_step_carry;

  seq_shift_rotate_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_op    (r_op),
    .i_val   (r_out),
    .o_val   (w_step_out),
    .o_carry (w_step_carry)
  );

  // A start is honoured in IDLE and DONE alike so requests can run back-to-back.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (number_bits == AMT_ZERO) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_count == AMT_ONE) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (number_bits == AMT_ZERO) ? S_DONE : S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= SH_LSL;
      r_count <= AMT_ZERO;
      r_out   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_SHIFT);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_op    <= op;
        r_out   <= source_1;
        r_carry <= 1'b0;
        r_count <= number_bits;
      end else if (r_state == S_SHIFT) begin
        r_out   <= w_step_out;
        r_carry <= w_step_carry;
        r_count <= r_count - AMT_ONE;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out       = r_out;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_seq_shift_rotate.sv
// Scoreboard bench for seq_shift_rotate: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is presented.
module tb_seq_shift_rotate;
  import seq_shift_rotate_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] source_1;
  logic [4:0]  number_bits;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        carry_out;

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          done_cyc;
    int          busy_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  int   busy_cnt = 0;

  seq_shift_rotate #(
    .WIDTH (32),
    .AMT_W (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .source_1    (source_1),
    .number_bits (number_bits),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .carry_out   (carry_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: compares every presented result against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
      end else begin
        chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("out", out, e.res);
            chk("carry_out", {31'd0, carry_out}, {31'd0, e.c});
            chk("done_cycle", cyc, e.done_cyc);
            chk("busy_cycles", busy_cnt, e.busy_cyc);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] src, input logic [5:0] n6,
                       input logic [31:0] exp_res, input logic exp_c);
    int eff;
    eff = int'(n6[4:0]);
    @(negedge clk);
    start       = 1'b1;
    op          = o;
    source_1    = src;
    number_bits = n6[4:0];
    @(posedge clk);
    #1;
    sb.push_back('{exp_res, exp_c, cyc + eff, eff});
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout_waiting_done", sb.size(), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    op          = SH_LSL;
    source_1    = 32'h0;
    number_bits = 5'd0;
    #12;
    chk("rst_out", out, 32'h0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(SH_LSL, 32'hFFFF_FFFF, 6'd1,  32'hFFFF_FFFE, 1'b1); drain();
    issue(SH_LSR, 32'h8000_0001, 6'd31, 32'h0000_0001, 1'b0); drain();
    issue(SH_ROR, 32'h0000_0001, 6'd4,  32'h1000_0000, 1'b0); drain();
    issue(SH_ROR, 32'h0000_000F, 6'd4,  32'hF000_0000, 1'b1); drain();

    // Result and carry must hold while idle.
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_out", out, 32'hF000_0000);
    chk("idle_hold_carry", {31'd0, carry_out}, 32'd1);

    issue(SH_ASR, 32'h8000_0000, 6'd31, 32'hFFFF_FFFF, 1'b0); drain();
    issue(SH_ASR, 32'h1234_5678, 6'd32, 32'h1234_5678, 1'b0); drain();
    issue(SH_LSL, 32'h0000_0005, 6'd0,  32'h0000_0005, 1'b0); drain();
    issue(SH_ROR, 32'h8000_0001, 6'd1,  32'hC000_0000, 1'b1); drain();

    // Back-to-back: start held high through SHIFT and into DONE.
    @(negedge clk);
    start       = 1'b1;
    op          = SH_LSL;
    source_1    = 32'h0000_0001;
    number_bits = 5'd2;
    @(posedge clk);
    #1;
    sb.push_back('{32'h0000_0004, 1'b0, cyc + 2, 2});
    op          = SH_LSR;
    source_1    = 32'h0000_0084;
    number_bits = 5'd3;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    sb.push_back('{32'h0000_0010, 1'b1, cyc + 3, 3});
    start = 1'b0;
    drain();

    // A start pulse during SHIFT must be ignored.
    issue(SH_ROR, 32'h8000_0005, 6'd3, 32'hB000_0000, 1'b1);
    @(negedge clk);
    start       = 1'b1;
    op          = SH_LSL;
    source_1    = 32'h0;
    number_bits = 5'd1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    start       = 1'b1;
    op          = SH_LSR;
    source_1    = 32'hFFFF_FFFF;
    number_bits = 5'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("mid_shift_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_out", out, 32'h0);
    chk("async_rst_carry", {31'd0, carry_out}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_idle_done", {31'd0, done}, 32'd0);

    issue(SH_LSL, 32'hFFFF_FFFF, 6'd3, 32'hFFFF_FFF8, 1'b1); drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
